// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit.
package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldivOpE;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } muldivStateE;

  // LO value written on divide-by-zero; sliced down to the configured width.
  localparam logic [127:0] DIV0_LO = '1;

endpackage

// File: rtl/mips_muldiv_sign_fix.sv
// Conditional two's-complement negation of the product, quotient and remainder.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic           negProd,
  input  logic [2*W-1:0] prodIn,
  output logic [2*W-1:0] prodOut,
  input  logic           negQuot,
  input  logic [W-1:0]   quotIn,
  output logic [W-1:0]   quotOut,
  input  logic           negRem,
  input  logic [W-1:0]   remIn,
  output logic [W-1:0]   remOut
);

  always_comb begin
    prodOut = negProd ? -prodIn : prodIn;
    quotOut = negQuot ? -quotIn : quotIn;
    remOut  = negRem  ? -remIn  : remIn;
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; W+1 cycle latency,
// stall request to hazard logic and flush for squashed instructions.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [DATA_WIDTH-1:0] hi_wdata,
  input  logic [DATA_WIDTH-1:0] lo_wdata,
  input  logic                  hilo_rd,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done,
  output logic                  stall_req
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  muldivStateE    state;
  muldivOpE       opReg;
  logic           signA;
  logic           signB;
  logic           divZero;
  logic [W-1:0]   rsRaw;
  logic [W-1:0]   bReg;
  logic [2*W-1:0] acc;
  logic [W-1:0]   remReg;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   hiReg;
  logic [W-1:0]   loReg;
  logic           doneReg;

  logic           signedIn;
  logic [W-1:0]   absRs;
  logic [W-1:0]   absRt;
  logic           opIsDiv;
  logic [W:0]     mulSum;
  logic [W:0]     divTrial;
  logic           divGe;
  logic [W-1:0]   divDiff;
  logic [2*W-1:0] prodFix;
  logic [W-1:0]   quotFix;
  logic [W-1:0]   remFix;

  always_comb begin
    signedIn = ~op[0];
    absRs    = (signedIn && rs_data[W-1]) ? -rs_data : rs_data;
    absRt    = (signedIn && rt_data[W-1]) ? -rt_data : rt_data;
    opIsDiv  = (opReg == OP_DIV) || (opReg == OP_DIVU);
    // Multiply: acc = {partial product, remaining multiplier bits}.
    mulSum   = {1'b0, acc[2*W-1:W]} + {1'b0, bReg & {W{acc[0]}}};
    // Divide: acc[W-1:0] shifts dividend bits out and quotient bits in.
    divTrial = {remReg, acc[W-1]};
    divGe    = (divTrial >= {1'b0, bReg});
    divDiff  = divTrial[W-1:0] - bReg;
  end

  muldiv_sign_fix #(.W(W)) uSignFix (
    .negProd (signA ^ signB),
    .prodIn  (acc),
    .prodOut (prodFix),
    .negQuot (signA ^ signB),
    .quotIn  (acc[W-1:0]),
    .quotOut (quotFix),
    .negRem  (signA),
    .remIn   (remReg),
    .remOut  (remFix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      opReg   <= OP_MULT;
      signA   <= 1'b0;
      signB   <= 1'b0;
      divZero <= 1'b0;
      rsRaw   <= '0;
      bReg    <= '0;
      acc     <= '0;
      remReg  <= '0;
      cnt     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !flush) begin
            opReg   <= muldivOpE'(op);
            signA   <= signedIn & rs_data[W-1];
            signB   <= signedIn & rt_data[W-1];
            divZero <= (rt_data == '0);
            rsRaw   <= rs_data;
            bReg    <= op[1] ? absRt : absRs;
            acc     <= {{W{1'b0}}, (op[1] ? absRs : absRt)};
            remReg  <= '0;
            cnt     <= '0;
            state   <= CALC;
          end else begin
            if (mthi) hiReg <= hi_wdata;
            if (mtlo) loReg <= lo_wdata;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (opIsDiv) begin
              acc    <= {acc[2*W-1:W], acc[W-2:0], divGe};
              remReg <= divGe ? divDiff : divTrial[W-1:0];
            end else begin
              acc <= {mulSum, acc[W-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= FINISH;
          end
        end
        FINISH: begin
          if (!flush) begin
            if (!opIsDiv) begin
              hiReg <= prodFix[2*W-1:W];
              loReg <= prodFix[W-1:0];
            end else if (divZero) begin
              hiReg <= rsRaw;
              loReg <= DIV0_LO[W-1:0];
            end else begin
              hiReg <= remFix;
              loReg <= quotFix;
            end
            doneReg <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    hi        = hiReg;
    lo        = loReg;
    done      = doneReg;
    busy      = (state != IDLE);
    stall_req = busy & (start | hilo_rd | mthi | mtlo);
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: vector table, random ops vs an
// arithmetic reference model, and hand-written flush/reset/MTHI sequences.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, mthi, mtlo, hilo_rd, flush;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, hi_wdata, lo_wdata;
  logic [31:0] hi, lo;
  logic        busy, done, stall_req;

  logic        start16;
  logic [1:0]  op16;
  logic [15:0] rs16, rt16, hi16, lo16;
  logic        busy16, done16, stall16;
  logic        zero1;
  logic [15:0] zero16;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .mthi(mthi), .mtlo(mtlo), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .hilo_rd(hilo_rd), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall_req(stall_req)
  );

  mips_muldiv_unit #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16),
    .rs_data(rs16), .rt_data(rt16),
    .mthi(zero1), .mtlo(zero1), .hi_wdata(zero16), .lo_wdata(zero16),
    .hilo_rd(zero1), .flush(zero1),
    .hi(hi16), .lo(lo16), .busy(busy16), .done(done16), .stall_req(stall16)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vecT;

  vecT vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end else begin
          r = {(ua % ub) & 64'hFFFF_FFFF, 32'b0} | ((ua / ub) & 64'hFFFF_FFFF);
        end
      end
    endcase
    return r;
  endfunction

  // Entered #1 after an edge; returns #1 after the edge where done is seen.
  task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rh, output logic [31:0] rl, output int cyc);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {63'b0, busy}, 64'd1);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_at_done", {63'b0, busy}, 64'd0);
    rh = hi;
    rl = lo;
  endtask

  initial begin
    logic [31:0] rh, rl, prevH, prevL;
    logic [63:0] exp;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          cyc;
    logic        sawDone;

    vecs[0] = '{2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{2'b11, 32'd100,        32'd7,         32'd2,         32'd14};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[4] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[6] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[7] = '{2'b10, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b0; flush = 1'b0;
    op = 2'b00; rs_data = '0; rt_data = '0; hi_wdata = '0; lo_wdata = '0;
    start16 = 1'b0; op16 = 2'b00; rs16 = '0; rt16 = '0; zero1 = 1'b0; zero16 = '0;
    #22;
    check("reset_outputs", {hi, lo}, 64'd0);
    check("reset_flags", {61'b0, busy, done, stall_req}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, cyc);
      check($sformatf("vec%0d_latency", i), 64'(cyc), 64'd33);
      check($sformatf("vec%0d_hilo", i), {rh, rl}, {vecs[i].eh, vecs[i].el});
    end

    for (int n = 0; n < 30; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
      runOp(ro, ra, rb, rh, rl, cyc);
      exp = model(ro, ra, rb);
      check($sformatf("rand%0d_op%0d", n, ro), {rh, rl}, exp);
    end

    // Flush at CALC cycle 10: no done, HI/LO untouched.
    prevH = hi; prevL = lo;
    op = 2'b01; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {62'b0, busy, done}, 64'd0);
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      sawDone |= done;
    end
    check("flush_no_done", {63'b0, sawDone}, 64'd0);
    check("flush_hilo_kept", {hi, lo}, {prevH, prevL});
    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, cyc);
    check("restart_hilo", {rh, rl}, 64'hFFFF_FFFE_0000_0001);

    // Flush in IDLE cancels a simultaneous start.
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idle_flush_cancels_start", {63'b0, busy}, 64'd0);

    // MTHI and a second start while busy are held off by stall_req.
    prevH = hi;
    op = 2'b11; rs_data = 32'd100; rt_data = 32'd7; mthi = 1'b1; hi_wdata = 32'hA5A5_A5A5; start = 1'b1;
    @(posedge clk); #1;
    check("mthi_with_start_ignored", {32'b0, hi}, {32'b0, prevH});
    #1;
    check("stall_busy_start_mthi", {63'b0, stall_req}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0; hilo_rd = 1'b1;
    #1;
    check("stall_busy_hilo_rd", {63'b0, stall_req}, 64'd1);
    hilo_rd = 1'b0;
    #1;
    check("no_stall_busy_quiet", {63'b0, stall_req}, 64'd0);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_op_result", {hi, lo}, {32'd2, 32'd14});
    @(posedge clk); #1;
    check("done_one_pulse", {63'b0, done}, 64'd0);

    mthi = 1'b1; mtlo = 1'b1; lo_wdata = 32'h1234_5678;
    #1;
    check("idle_no_stall", {63'b0, stall_req}, 64'd0);
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo_idle", {hi, lo}, {32'hA5A5_A5A5, 32'h1234_5678});

    // Reset in the middle of CALC clears HI/LO immediately.
    op = 2'b00; rs_data = 32'd9; rt_data = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset_mid_calc_hilo", {hi, lo}, 64'd0);
    check("reset_mid_calc_busy", {63'b0, busy}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Narrow instance: MULT 7 x -3 at 16 bits.
    op16 = 2'b00; rs16 = 16'd7; rt16 = 16'hFFFD; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w16_latency", 64'(cyc), 64'd17);
    check("w16_hilo", {32'b0, hi16, lo16}, {32'b0, 16'hFFFF, 16'hFFEB});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core, generalised to a parametrised data width. It sits beside the ALU in the EX stage and executes MULT, MULTU, DIV and DIVU over several cycles. It raises a stall request toward the hazard logic while HI/LO are not yet valid, and supports flush for squashed instructions.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width (W); must be an even number of at least 8.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  launch an operation with op/rs_data/rt_data; accepted only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  in  W  multiplicand / dividend
- rt_data  in  W  multiplier / divisor
- mthi  in  1  write hi_wdata into HI
- mtlo  in  1  write lo_wdata into LO
- hi_wdata  in  W  MTHI data
- lo_wdata  in  W  MTLO data
- hilo_rd  in  1  EX-stage instruction is MFHI/MFLO
- flush  in  1  abort the in-flight operation
- hi  out  W  HI register
- lo  out  W  LO register
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO take a result
- stall_req  out  1  busy & (start | hilo_rd | mthi | mtlo)

## Operation
- FSM states: IDLE, CALC, FINISH.
- **IDLE**
  - start=1 latches |rs|, |rt| (magnitudes for signed ops, raw values for unsigned ops), the op, and both sign bits.
  - Clears the counter and moves to CALC.
- **CALC** runs exactly W iterations, one per cycle; counter 0..W-1, then FINISH.
  - Multiply: shift-add on a 2W accumulator, taking one multiplier bit per cycle, LSB first.
  - Divide: restoring division with a W+1-bit partial remainder, one quotient bit per cycle, MSB first.
- **FINISH**
  - Applies sign correction:
    - signed product negated if sign_a ^ sign_b;
    - quotient negated if sign_a ^ sign_b;
    - remainder takes sign_a.
  - Writes HI/LO: multiply gives HI=product[2W-1:W], LO=product[W-1:0]; divide gives LO=quotient, HI=remainder.
  - Pulses done, then returns to IDLE.
- Divide by zero (rt=0), both DIV and DIVU: HI=rs_data as given (original dividend), LO=all ones. The latency is unchanged.
- Signed overflow (most negative / -1): LO=most negative value, HI=0. This falls out of the arithmetic naturally.
- mthi/mtlo:
  - applied in IDLE only;
  - ignored while busy (stall_req holds the pipeline);
  - ignored in the same cycle as an accepted start.
- start while busy: ignored; stall_req=1.
- flush:
  - in CALC or FINISH: returns to IDLE next edge, with no HI/LO update and no done;
  - in IDLE: cancels a simultaneous start.
- flush has priority over FINISH completion.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, stall_req=0; state IDLE.
- start sampled at edge 0:
  - busy=1 from edge 0 through edge W+1 (W+1 cycles: W CALC cycles plus 1 FINISH cycle);
  - done=1 and HI/LO updated at edge W+1;
  - busy=0 after edge W+1.
- Latency, start to new HI/LO visible: W+1 cycles (33 at W=32).
- Back-to-back: a new start is accepted in the cycle after done.
- MTHI/MTLO latency: one cycle.
- Reset mid-operation: immediate return to IDLE with HI/LO cleared.
- stall_req is combinational from busy and the inputs. There is no combinational path from rs_data or rt_data to any output.

## Structure
- Shared package mips_muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - the state enum IDLE/CALC/FINISH;
  - the divide-by-zero LO constant (all ones).
- One sub-module, muldiv_sign_fix: combinational, two's-complement negate-if of the W-bit and 2W-bit results, instantiated once.
- Counter width is $clog2(DATA_WIDTH).

## Test plan
- MULT 7 × 0xFFFFFFFD (-3) → done at 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIVU 100 / 7 → LO=14, HI=2. DIV 0xFFFFFFF9 (-7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 5 / 0 → HI=5, LO=0xFFFFFFFF, done still at cycle 33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, then flush at CALC cycle 10 → busy=0 next cycle, no done, HI/LO keep prior values; then a restart completes correctly.
- mthi=1 with hi_wdata=0xA5A5A5A5 while busy, plus start while busy → stall_req=1, HI unchanged. The same write in IDLE → HI=0xA5A5A5A5 after 1 cycle.
- Assert reset mid-CALC → hi=lo=0, busy=0 immediately. Repeat the MULT case with DATA_WIDTH=16: 7 × 0xFFFD → HI=0xFFFF, LO=0xFFEB at 17 cycles.
